// File: rtl/spi_periph_pkg.sv
// Shared types, default parameters and helpers for the SPI register-file peripheral.
package spi_periph_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} spi_state_t;

  localparam int DefAddrW       = 8;
  localparam int DefDataW       = 8;
  localparam int DefNumRegs     = 8;
  localparam int DefInstAddr    = 2;
  localparam int DefNumInst     = 3;
  localparam int DefRoAddr      = 60;
  localparam int DefIdleTimeout = 16;
  localparam int MaxInst        = 32;

  // One-hot pulse vector for instruction code 1..numInst; anything else yields zero.
  function automatic logic [MaxInst-1:0] instOneHot(input int unsigned code, input int unsigned numInst);
    logic [MaxInst-1:0] v;
    v = '0;
    if (code >= 1 && code <= numInst && code <= MaxInst)
      v = {{(MaxInst-1){1'b0}}, 1'b1} << (code - 1);
    return v;
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchroniser for an asynchronous input, with a history flop for rise/fall detection.
module spi_edge_sync (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  // Synchronise the pad level and keep one cycle of history for edge detection.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_regfile_periph.sv
// SPI-to-register-file slave on the internal clock: address phase, auto-incrementing
// data words, instruction pulse at frame end. Optional readback on serial_out is
// enabled by defining the macro SPI_RDBACK_EN.
module spi_regfile_periph
  import spi_periph_pkg::*;
#(
  parameter int ADDR_W       = DefAddrW,
  parameter int DATA_W       = DefDataW,
  parameter int NUM_REGS     = DefNumRegs,
  parameter int INST_ADDR    = DefInstAddr,
  parameter int NUM_INST     = DefNumInst,
  parameter int RO_ADDR      = DefRoAddr,
  parameter int IDLE_TIMEOUT = DefIdleTimeout
) (
  input  logic                         iclk,
  input  logic                         rstn,
  input  logic                         sclk,
  input  logic                         serial_in,
  input  logic [DATA_W-1:0]            ro_in,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  output logic [NUM_INST-1:0]          inst_pulse,
  output logic                         busy,
  output logic                         serial_out
);

  localparam int ShW  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int BitW = $clog2(ShW + 1);
  localparam int ToW  = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] RoAddr   = ADDR_W'(RO_ADDR);
  localparam logic [ADDR_W-1:0] InstAddr = ADDR_W'(INST_ADDR);
  localparam logic [BitW-1:0]   AddrLast = BitW'(ADDR_W - 1);
  localparam logic [BitW-1:0]   DataLast = BitW'(DATA_W - 1);
  localparam logic [ToW-1:0]    ToLast   = ToW'(IDLE_TIMEOUT - 1);
  localparam logic [ToW-1:0]    ToMax    = ToW'(IDLE_TIMEOUT);

  logic unusedSclkLevel, sclkRise, sclkFall, sclkEdge;
  logic sinMeta_q, sinSync_q;
  spi_state_t state_q;
  logic [BitW-1:0] bitCnt_q;
  logic [ShW-1:0] shift_q, shift_d;
  logic [ADDR_W-1:0] ptr_q, loadPtr_d;
  logic [ToW-1:0] toCnt_q;
  logic instWritten_q;
  logic [NUM_INST-1:0] instPulse_q, instPulse_d;
  logic [MaxInst-1:0] instVec;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] word_d;
  logic [NUM_REGS-1:0] wrSel;
  logic addrDone, wordDone, toExpire;

  spi_edge_sync uSclkSync (
    .clk_i  (iclk),
    .rstn_i (rstn),
    .d_i    (sclk),
    .sync_o (unusedSclkLevel),
    .rise_o (sclkRise),
    .fall_o (sclkFall)
  );

  assign sclkEdge = sclkRise | sclkFall;

  // Serial data only needs the level, aligned with the synchronised sclk.
  always_ff @(posedge iclk) begin
    if (!rstn) begin
      sinMeta_q <= 1'b0;
      sinSync_q <= 1'b0;
    end else begin
      sinMeta_q <= serial_in;
      sinSync_q <= sinMeta_q;
    end
  end

  // Phase completion, timeout, write select and next pointer decode.
  always_comb begin
    shift_d     = {shift_q[ShW-2:0], sinSync_q};
    word_d      = shift_d[DATA_W-1:0];
    addrDone    = (state_q == ADDR) && sclkRise && (bitCnt_q == AddrLast);
    wordDone    = (state_q == DATA) && sclkRise && (bitCnt_q == DataLast);
    toExpire    = (state_q != IDLE) && !sclkEdge && (toCnt_q == ToLast);
    loadPtr_d   = addrDone ? shift_d[ADDR_W-1:0] : ptr_q + 1'b1;
    instVec     = instOneHot(32'(regs_q[INST_ADDR]), NUM_INST);
    instPulse_d = instVec[NUM_INST-1:0];
    wrSel       = '0;
    for (int i = 0; i < NUM_REGS; i++)
      wrSel[i] = wordDone && (ptr_q == ADDR_W'(i)) && (ptr_q != RoAddr);
  end

  // Frame FSM, register bank, timeout counter and instruction pulse.
  always_ff @(posedge iclk) begin
    if (!rstn) begin
      state_q       <= IDLE;
      bitCnt_q      <= '0;
      shift_q       <= '0;
      ptr_q         <= '0;
      toCnt_q       <= '0;
      instWritten_q <= 1'b0;
      instPulse_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      instPulse_q <= '0;
      if (sclkEdge)
        toCnt_q <= '0;
      else if (state_q != IDLE && toCnt_q != ToMax)
        toCnt_q <= toCnt_q + 1'b1;
      for (int i = 0; i < NUM_REGS; i++)
        if (wrSel[i]) regs_q[i] <= word_d;
      if (toExpire) begin
        state_q  <= IDLE;
        bitCnt_q <= '0;
        if (instWritten_q) instPulse_q <= instPulse_d;
        instWritten_q <= 1'b0;
      end else if (sclkRise) begin
        shift_q <= shift_d;
        case (state_q)
          IDLE: begin
            bitCnt_q <= BitW'(1);
            state_q  <= ADDR;
          end
          ADDR: begin
            if (addrDone) begin
              ptr_q    <= loadPtr_d;
              bitCnt_q <= '0;
              state_q  <= DATA;
            end else begin
              bitCnt_q <= bitCnt_q + 1'b1;
            end
          end
          DATA: begin
            if (wordDone) begin
              ptr_q    <= loadPtr_d;
              bitCnt_q <= '0;
              if (ptr_q == InstAddr) instWritten_q <= 1'b1;
            end else begin
              bitCnt_q <= bitCnt_q + 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef SPI_RDBACK_EN
  logic [DATA_W-1:0] tx_q, rdVal_d;
  logic serOut_q;

  // Read value of the pointer being loaded; a same-cycle write is forwarded.
  always_comb begin
    rdVal_d = '0;
    if (loadPtr_d == RoAddr) rdVal_d = ro_in;
    for (int i = 0; i < NUM_REGS; i++)
      if (loadPtr_d == ADDR_W'(i)) rdVal_d = wrSel[i] ? word_d : regs_q[i];
  end

  // Load the tx word at each phase boundary and shift it out MSB first on sclk falls.
  always_ff @(posedge iclk) begin
    if (!rstn) begin
      tx_q     <= '0;
      serOut_q <= 1'b0;
    end else if (toExpire) begin
      serOut_q <= 1'b0;
    end else if (addrDone || wordDone) begin
      tx_q <= rdVal_d;
    end else if (state_q == DATA && sclkFall) begin
      serOut_q <= tx_q[DATA_W-1];
      tx_q     <= tx_q << 1;
    end
  end

  assign serial_out = serOut_q;
`else
  logic [DATA_W-1:0] unusedRo;
  assign unusedRo   = ro_in;
  assign serial_out = 1'b0;
`endif

  for (genvar g = 0; g < NUM_REGS; g++) begin : gFlat
    assign reg_q[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign inst_pulse = instPulse_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: doc/spi_regfile_periph.md
Name: spi_regfile_periph

Overview:
- Parametrised successor of the SPI command peripheral: a fully synchronous SPI-to-register-file slave running on the internal clock.
- Oversamples sclk and serial_in, decodes an address phase followed by auto-incrementing data phases, and writes a generic register bank.
- Shifts back the prior register contents on serial_out, and issues single-cycle instruction pulses when a frame ends on sclk idle timeout.
- Sits between the chip pads and the analog/trigger configuration logic.

Parameters:
- ADDR_W, 8, address phase width in bits.
- DATA_W, 8, data word width in bits.
- NUM_REGS, 8, number of writable registers, addresses 0..NUM_REGS-1.
- INST_ADDR, 2, register address whose write triggers an instruction pulse at frame end.
- NUM_INST, 3, number of instruction codes (1..NUM_INST).
- RO_ADDR, 8'd60, read-only address returning ro_in; writes ignored.
- IDLE_TIMEOUT, 16, iclk cycles without an sclk edge that end a frame.

Ports:
- iclk  in  1  internal clock, sole clock.
- rstn  in  1  synchronous active-low reset.
- sclk  in  1  asynchronous SPI clock, sampled on iclk.
- serial_in  in  1  SPI data in, MSB first.
- ro_in  in  DATA_W  read-only status word (e.g. pll_locked).
- reg_q  out  NUM_REGS*DATA_W  flattened register contents; reg i at [i*DATA_W +: DATA_W].
- inst_pulse  out  NUM_INST  one-hot, one-iclk pulse; bit k means code k+1.
- busy  out  1  high while a frame is active (state != IDLE).
- serial_out  out  1  readback data, MSB first.

Behaviour:
- Reset: synchronous on iclk when rstn=0. All reg_q=0, inst_pulse=0, busy=0, serial_out=0, state=IDLE, bit counter=0, address pointer=0, timeout counter=0, inst_written flag=0.
- Input sync: sclk and serial_in each pass through 2 flops. A third sclk flop gives rise/fall detect. Data is sampled on a detected rise, 3 iclk after the pad edge. Requires iclk >= 4x sclk.
- FSM:
  - IDLE: on first rise, shift in bit and go to ADDR.
  - ADDR: on the ADDR_W-th bit, ptr <= shifted address; go to DATA. Load the tx shift register with the read value of the new ptr.
  - DATA: on every DATA_W-th bit:
    - If ptr < NUM_REGS, reg[ptr] <= word. If ptr == INST_ADDR, set inst_written.
    - ptr <= ptr+1, wrapping mod 2^ADDR_W.
    - Reload the tx register from the new ptr.
  - Any state: timeout counter reaches IDLE_TIMEOUT, go to IDLE.
- Read value: reg[ptr] if ptr < NUM_REGS; ro_in if ptr == RO_ADDR; otherwise 0. ro_in is captured at load time.
- Write policy:
  - Writes to RO_ADDR or any ptr >= NUM_REGS are discarded; ptr still increments.
  - A write and a readback-load of the same address in the same cycle returns the new value.
- serial_out: on each detected sclk fall in DATA, output the tx MSB and shift left. Otherwise hold. Returns to 0 on entering IDLE.
- Timeout counter: cleared on any sclk edge; saturates at IDLE_TIMEOUT; counts only when state != IDLE.
- Frame end (IDLE entry):
  - A partial word or partial address is discarded.
  - If inst_written and 1 <= reg[INST_ADDR] <= NUM_INST, assert inst_pulse[reg[INST_ADDR]-1] for exactly one cycle, then clear inst_written.
  - Invalid codes give no pulse.
- Simultaneous sclk edge and timeout: the edge wins and the counter clears.
- Reset mid-frame aborts the frame: no pulse, registers zeroed.

Optional Feature:
- Macro SPI_RDBACK_EN.
- Defined: readback path as above.
- Undefined: tx shift register and read mux are removed; serial_out is tied to 0 and ro_in is unused. Writes and pulses are unchanged.

Decomposition:
- Package spi_periph_pkg holds:
  - typedef enum {IDLE, ADDR, DATA} spi_state_t;
  - default parameter constants;
  - a function computing the one-hot instruction pulse from a code.
- One sub-module: spi_edge_sync (2-flop synchroniser plus rise/fall detect), instantiated for sclk. serial_in uses only its sync output.

Test Plan (parameters at defaults; 4 iclk per sclk half-period):
- Write frame addr 0x00, data 0xA5, 0x3C, then idle 20 cycles -> reg0=0xA5, reg1=0x3C; busy falls 16 iclk after the last edge; inst_pulse stays 0.
- Addr 0x02, data 0x03, then idle -> inst_pulse=3'b100 for one cycle at IDLE entry. Repeat with data 0x05 -> no pulse.
- Preload reg3=0x96; frame addr 0x03, data 0x00 -> serial_out bits 1,0,0,1,0,1,1,0 on successive falls; reg3 becomes 0x00.
- ro_in=0x81; addr 60 (0x3C), data 0xFF -> serial_out returns 0x81; no reg_q change.
- Addr 0x07, data 0x11, 0x22 -> reg7=0x11; ptr moves to 8 and 0x22 is discarded. Addr 0xFF with two words -> ptr wraps to 0 and reg0=second word.
- Rstn low for one cycle mid-data with reg[2] written earlier -> all reg_q=0, busy=0, no inst_pulse. A frame with 5 bits then timeout -> no register change.
